// File: rtl/dg0045_fetch_seq.sv
// DG0045 machine-cycle sequencer and instruction-fetch controller.
// Eight clk phases per machine cycle; owns the PC, fetches opcode/operand, strobes execute.
module dg0045_fetch_seq #(
    parameter logic [9:0] RESET_PC    = 10'h000,
    parameter logic [1:0] LONG_PREFIX = 2'b11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_i,
    input  logic [7:0] rom_data_i,
    output logic [4:0] pc_hl_o,
    output logic       pc_hi_sel_o,
    output logic [9:0] pc_o,
    output logic [2:0] phase_o,
    output logic [7:0] ir_o,
    output logic [7:0] operand_o,
    output logic       long_op_o,
    output logic       exe_stb_o,
    input  logic       jump_req_i,
    input  logic [9:0] jump_addr_i,
    input  logic       skip_req_i
);

    typedef enum logic [0:0] {StFetchOp, StFetchArg} state_e;

    state_e     state_q, state_d;
    logic [2:0] phase_q, phase_d;
    logic [9:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] operand_q, operand_d;
    logic       skip_pend_q, skip_pend_d;

    logic long_op;
    logic completes;
    logic exe_stb;

    assign long_op = (ir_q[7:6] == LONG_PREFIX);
    // A cycle ends an instruction if it fetched a short opcode or the operand byte.
    assign completes = ((state_q == StFetchOp) && !long_op) || (state_q == StFetchArg);
    assign exe_stb = ena_i && (phase_q == 3'd7) && completes && !skip_pend_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        operand_d   = operand_q;
        skip_pend_d = skip_pend_q;
        if (ena_i) begin
            phase_d = phase_q + 3'd1;
            if (phase_q == 3'd6) begin
                if (state_q == StFetchOp) begin
                    ir_d = rom_data_i;
                end else begin
                    operand_d = rom_data_i;
                end
            end
            if (phase_q == 3'd7) begin
                unique case (state_q)
                    StFetchOp:  state_d = long_op ? StFetchArg : StFetchOp;
                    StFetchArg: state_d = StFetchOp;
                    default:    state_d = StFetchOp;
                endcase
                pc_d = (exe_stb && jump_req_i) ? jump_addr_i : pc_q + 10'd1;
                if (exe_stb && skip_req_i && !jump_req_i) begin
                    skip_pend_d = 1'b1;
                end else if (completes) begin
                    skip_pend_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFetchOp;
            phase_q     <= 3'd0;
            pc_q        <= RESET_PC;
            ir_q        <= 8'h00;
            operand_q   <= 8'h00;
            skip_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            operand_q   <= operand_d;
            skip_pend_q <= skip_pend_d;
        end
    end

    // Phases 0-2 carry the low half; 3-7 carry the high half.
    assign pc_hi_sel_o = (phase_q >= 3'd3);
    assign pc_hl_o     = pc_hi_sel_o ? pc_q[9:5] : pc_q[4:0];
    assign pc_o        = pc_q;
    assign phase_o     = phase_q;
    assign ir_o        = ir_q;
    assign operand_o   = operand_q;
    assign long_op_o   = long_op;
    assign exe_stb_o   = exe_stb;

endmodule

// File: tb/tb_dg0045_fetch_seq.sv
// Directed bench for dg0045_fetch_seq: one table row per machine cycle,
// plus hand-written stall, wrap and mid-cycle reset sequences.
module tb_dg0045_fetch_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] rom_data;
    logic [4:0] pc_hl;
    logic       pc_hi_sel;
    logic [9:0] pc;
    logic [2:0] phase;
    logic [7:0] ir;
    logic [7:0] operand;
    logic       long_op;
    logic       exe_stb;
    logic       jump_req;
    logic [9:0] jump_addr;
    logic       skip_req;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dg0045_fetch_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena_i       (ena),
        .rom_data_i  (rom_data),
        .pc_hl_o     (pc_hl),
        .pc_hi_sel_o (pc_hi_sel),
        .pc_o        (pc),
        .phase_o     (phase),
        .ir_o        (ir),
        .operand_o   (operand),
        .long_op_o   (long_op),
        .exe_stb_o   (exe_stb),
        .jump_req_i  (jump_req),
        .jump_addr_i (jump_addr),
        .skip_req_i  (skip_req)
    );

    typedef struct {
        logic [7:0] rom;
        logic       jmp;
        logic [9:0] jaddr;
        logic       skip;
        logic [4:0] lo;
        logic [4:0] hi;
        int         stb;
        logic [7:0] ir;
        logic [7:0] opnd;
        logic       lng;
        logic [9:0] pc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [4:0] hl_lo, hl_hi;
        int         stb_cnt;
        logic       seq_ok;

        //          rom    jmp   jaddr    skip  lo     hi     stb ir     opnd   lng   pc
        vecs[0] = '{8'h00, 1'b1, 10'h025, 1'b0, 5'h00, 5'h00, 1,  8'h00, 8'h00, 1'b0, 10'h025};
        vecs[1] = '{8'h3A, 1'b0, 10'h000, 1'b0, 5'h05, 5'h01, 1,  8'h3A, 8'h00, 1'b0, 10'h026};
        vecs[2] = '{8'hC4, 1'b1, 10'h100, 1'b0, 5'h06, 5'h01, 0,  8'hC4, 8'h00, 1'b1, 10'h027};
        vecs[3] = '{8'h7E, 1'b0, 10'h000, 1'b0, 5'h07, 5'h01, 1,  8'hC4, 8'h7E, 1'b1, 10'h028};
        vecs[4] = '{8'h12, 1'b1, 10'h3F0, 1'b0, 5'h08, 5'h01, 1,  8'h12, 8'h7E, 1'b0, 10'h3F0};
        vecs[5] = '{8'h05, 1'b0, 10'h000, 1'b1, 5'h10, 5'h1F, 1,  8'h05, 8'h7E, 1'b0, 10'h3F1};
        vecs[6] = '{8'hC4, 1'b0, 10'h000, 1'b0, 5'h11, 5'h1F, 0,  8'hC4, 8'h7E, 1'b1, 10'h3F2};
        vecs[7] = '{8'h5B, 1'b0, 10'h000, 1'b0, 5'h12, 5'h1F, 0,  8'hC4, 8'h5B, 1'b1, 10'h3F3};
        vecs[8] = '{8'h21, 1'b1, 10'h3FE, 1'b1, 5'h13, 5'h1F, 1,  8'h21, 8'h5B, 1'b0, 10'h3FE};
        vecs[9] = '{8'h22, 1'b0, 10'h000, 1'b0, 5'h1E, 5'h1F, 1,  8'h22, 8'h5B, 1'b0, 10'h3FF};

        rst_n     = 1'b0;
        ena       = 1'b1;
        rom_data  = 8'h00;
        jump_req  = 1'b0;
        jump_addr = 10'h000;
        skip_req  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("reset phase", 32'(phase), 32'd0);
        chk("reset pc", 32'(pc), 32'h000);
        chk("reset pc_hl", 32'(pc_hl), 32'h00);
        chk("reset pc_hi_sel", 32'(pc_hi_sel), 32'd0);
        chk("reset exe_stb", 32'(exe_stb), 32'd0);
        chk("reset ir", 32'(ir), 32'h00);
        chk("reset long_op", 32'(long_op), 32'd0);

        // Each row runs from one phase-0 sample point to the next.
        for (int v = 0; v < 10; v++) begin
            rom_data  = vecs[v].rom;
            jump_req  = vecs[v].jmp;
            jump_addr = vecs[v].jaddr;
            skip_req  = vecs[v].skip;
            stb_cnt   = 0;
            seq_ok    = 1'b1;
            hl_lo     = 5'h00;
            hl_hi     = 5'h00;
            for (int p = 0; p < 8; p++) begin
                if (phase !== 3'(p)) seq_ok = 1'b0;
                if (pc_hi_sel !== (p >= 3)) seq_ok = 1'b0;
                if (exe_stb === 1'b1 && p != 7) seq_ok = 1'b0;
                if (p == 0) hl_lo = pc_hl;
                if (p == 3) hl_hi = pc_hl;
                if (exe_stb === 1'b1) stb_cnt++;
                @(negedge clk);
            end
            chk($sformatf("v%0d phase/sel/stb timing", v), 32'(seq_ok), 32'd1);
            chk($sformatf("v%0d pc_hl low", v), 32'(hl_lo), 32'(vecs[v].lo));
            chk($sformatf("v%0d pc_hl high", v), 32'(hl_hi), 32'(vecs[v].hi));
            chk($sformatf("v%0d exe_stb count", v), 32'(stb_cnt), 32'(vecs[v].stb));
            chk($sformatf("v%0d ir", v), 32'(ir), 32'(vecs[v].ir));
            chk($sformatf("v%0d operand", v), 32'(operand), 32'(vecs[v].opnd));
            chk($sformatf("v%0d long_op", v), 32'(long_op), 32'(vecs[v].lng));
            chk($sformatf("v%0d pc", v), 32'(pc), 32'(vecs[v].pc));
        end

        // Stall at phase 4 with pc=0x3FF, then resume and wrap.
        jump_req = 1'b0;
        skip_req = 1'b0;
        rom_data = 8'h33;
        repeat (4) @(negedge clk);
        ena = 1'b0;
        stb_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (exe_stb === 1'b1) stb_cnt++;
        end
        chk("stall phase", 32'(phase), 32'd4);
        chk("stall pc_hl", 32'(pc_hl), 32'h1F);
        chk("stall pc_hi_sel", 32'(pc_hi_sel), 32'd1);
        chk("stall pc", 32'(pc), 32'h3FF);
        chk("stall exe_stb", 32'(stb_cnt), 32'd0);
        ena = 1'b1;
        repeat (3) @(negedge clk);
        chk("resume phase", 32'(phase), 32'd7);
        chk("resume exe_stb", 32'(exe_stb), 32'd1);
        ena = 1'b0;
        #1;
        chk("stall at T7 exe_stb", 32'(exe_stb), 32'd0);
        @(negedge clk);
        chk("stall at T7 phase", 32'(phase), 32'd7);
        chk("stall at T7 pc", 32'(pc), 32'h3FF);
        ena = 1'b1;
        @(negedge clk);
        chk("wrap pc", 32'(pc), 32'h000);
        chk("wrap phase", 32'(phase), 32'd0);
        chk("wrap ir", 32'(ir), 32'h33);

        // Mid-cycle reset at phase 5 during a long fetch.
        rom_data = 8'hC9;
        repeat (5) @(negedge clk);
        chk("pre-reset phase", 32'(phase), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("mid reset phase", 32'(phase), 32'd0);
        chk("mid reset pc", 32'(pc), 32'h000);
        chk("mid reset pc_hl", 32'(pc_hl), 32'h00);
        chk("mid reset pc_hi_sel", 32'(pc_hi_sel), 32'd0);
        chk("mid reset exe_stb", 32'(exe_stb), 32'd0);
        chk("mid reset ir", 32'(ir), 32'h00);
        chk("mid reset operand", 32'(operand), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post reset phase", 32'(phase), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
